// File: rtl/memory_tester_pkg.sv
// rtl/memory_tester_pkg.sv - shared FSM state type and test pattern function for memory_tester
package memory_tester_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  // Pattern arithmetic is done at a fixed width; callers keep the low DAT_WIDTH bits.
  localparam int PAT_WIDTH = 32;

  // Address value XOR all-p: plain pattern on pass 0, inverted on pass 1.
  function automatic logic [PAT_WIDTH-1:0] pat(input logic p, input logic [PAT_WIDTH-1:0] i);
    return i ^ {PAT_WIDTH{p}};
  endfunction

endpackage

// File: rtl/memory_tester_if.sv
// rtl/memory_tester_if.sv - single-port RAM bus between memory_tester and the RAM
interface memory_tester_if #(
  parameter int ADD_WIDTH = 10,
  parameter int DAT_WIDTH = 8
);
  logic [ADD_WIDTH-1:0] add;
  logic [DAT_WIDTH-1:0] dataW;
  logic [DAT_WIDTH-1:0] dataR;
  logic                 en;
  logic                 we;

  modport master (output add, output dataW, output en, output we, input dataR);
  modport slave  (input add, input dataW, input en, input we, output dataR);
endinterface

// File: rtl/memory_tester_rd_checker.sv
// rtl/memory_tester_rd_checker.sv - read-back compare pipeline with error count and first-error capture
module rd_checker #(
  parameter int ADD_WIDTH = 10,
  parameter int DAT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_valid,
  input  logic [ADD_WIDTH-1:0] rd_add,
  input  logic [DAT_WIDTH-1:0] rd_exp,
  input  logic [DAT_WIDTH-1:0] dataR,
  output logic                 error,
  output logic [ADD_WIDTH+1:0] err_count,
  output logic [ADD_WIDTH-1:0] err_add
);

  localparam logic [ADD_WIDTH+1:0] COUNT_ONE = (ADD_WIDTH+2)'(1);

  logic                 chk_valid;
  logic [DAT_WIDTH-1:0] exp_q;
  logic [ADD_WIDTH-1:0] add_q;
  logic                 mismatch;

  // RAM data for the read issued last cycle is on dataR now.
  assign mismatch = chk_valid && (dataR != exp_q);

  // Track the in-flight read and accumulate sticky error status.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_valid <= 1'b0;
      exp_q     <= '0;
      add_q     <= '0;
      error     <= 1'b0;
      err_count <= '0;
      err_add   <= '0;
    end else begin
      chk_valid <= rd_valid;
      exp_q     <= rd_exp;
      add_q     <= rd_add;
      if (mismatch) begin
        error <= 1'b1;
        if (err_count != '1) begin
          err_count <= err_count + COUNT_ONE;
        end
        if (!error) begin
          err_add <= add_q;
        end
      end
    end
  end

endmodule

// File: rtl/memory_tester.sv
// rtl/memory_tester.sv - two-pass write-all/read-all/compare engine for a single-port RAM
module memory_tester
  import memory_tester_pkg::*;
#(
  parameter int ADD_WIDTH = 10,
  parameter int DAT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  memory_tester_if.master      bus,
  output logic                 done,
  output logic                 error,
  output logic [ADD_WIDTH+1:0] err_count,
  output logic [ADD_WIDTH-1:0] err_add
);

  localparam logic [ADD_WIDTH-1:0] ADD_ONE = ADD_WIDTH'(1);

  state_t               state, state_n;
  logic [ADD_WIDTH-1:0] cnt, cnt_n;
  logic                 pass, pass_n;
  logic [PAT_WIDTH-1:0] wr_pat, rd_pat;

  // Next state, address and pass; the address wrap ends a phase with no extra cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pass_n  = pass;
    case (state)
      IDLE: begin
        state_n = WRITE;
        cnt_n   = '0;
      end
      WRITE: begin
        cnt_n = cnt + ADD_ONE;
        if (cnt == '1) state_n = READ;
      end
      READ: begin
        cnt_n = cnt + ADD_ONE;
        if (cnt == '1) state_n = DRAIN;
      end
      DRAIN: begin
        if (!pass) begin
          pass_n  = 1'b1;
          state_n = WRITE;
        end else begin
          state_n = DONE;
        end
      end
      DONE:    state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  assign wr_pat = pat(pass_n, PAT_WIDTH'(cnt_n));
  assign rd_pat = pat(pass, PAT_WIDTH'(cnt));

  // State registers; bus outputs are registered from next-state so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pass      <= 1'b0;
      bus.add   <= '0;
      bus.dataW <= '0;
      bus.en    <= 1'b0;
      bus.we    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pass      <= pass_n;
      bus.add   <= cnt_n;
      bus.dataW <= (state_n == WRITE) ? wr_pat[DAT_WIDTH-1:0] : '0;
      bus.en    <= (state_n == WRITE) || (state_n == READ);
      bus.we    <= (state_n == WRITE);
      done      <= (state_n == DONE);
    end
  end

  rd_checker #(
    .ADD_WIDTH (ADD_WIDTH),
    .DAT_WIDTH (DAT_WIDTH)
  ) u_rd_checker (
    .clk       (clk),
    .rst       (rst),
    .rd_valid  (state == READ),
    .rd_add    (cnt),
    .rd_exp    (rd_pat[DAT_WIDTH-1:0]),
    .dataR     (bus.dataR),
    .error     (error),
    .err_count (err_count),
    .err_add   (err_add)
  );

endmodule

// File: tb/tb_memory_tester.sv
// tb/tb_memory_tester.sv - scoreboard bench for memory_tester with a faultable RAM model
module tb_memory_tester;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   fault_mode = 0;
  int   rd_ops = 0;

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // default config DUT
  memory_tester_if #(.ADD_WIDTH(10), .DAT_WIDTH(8)) bus_a ();
  logic        done_a, error_a;
  logic [11:0] err_count_a;
  logic [9:0]  err_add_a;

  memory_tester #(.ADD_WIDTH(10), .DAT_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.master),
    .done(done_a), .error(error_a), .err_count(err_count_a), .err_add(err_add_a)
  );

  // small config DUT
  memory_tester_if #(.ADD_WIDTH(4), .DAT_WIDTH(8)) bus_b ();
  logic       done_b, error_b;
  logic [5:0] err_count_b;
  logic [3:0] err_add_b;

  memory_tester #(.ADD_WIDTH(4), .DAT_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.master),
    .done(done_b), .error(error_b), .err_count(err_count_b), .err_add(err_add_b)
  );

  // RAM models: 1-cycle read latency, optional fault on the large one
  logic [7:0] mem_a [1024];
  logic [7:0] rd_a = 8'h00;
  logic       flip_a = 1'b0;
  logic [7:0] mem_b [16];
  logic [7:0] rd_b = 8'h00;

  always @(posedge clk) begin
    if (rst) rd_ops <= 0;
    if (bus_a.en) begin
      if (bus_a.we) mem_a[bus_a.add] <= bus_a.dataW;
      else begin
        rd_a   <= mem_a[bus_a.add];
        flip_a <= (fault_mode == 2) && (rd_ops >= 1024) && (bus_a.add == 10'h155);
        if (!rst) rd_ops <= rd_ops + 1;
      end
    end
    if (bus_b.en) begin
      if (bus_b.we) mem_b[bus_b.add] <= bus_b.dataW;
      else rd_b <= mem_b[bus_b.add];
    end
  end

  assign bus_a.dataR = (fault_mode == 1) ? (rd_a & 8'hF7) : (flip_a ? ~rd_a : rd_a);
  assign bus_b.dataR = rd_b;

  typedef struct {
    logic        en;
    logic        we;
    logic [31:0] add;
    logic [31:0] data;
    logic        done;
  } ent_t;

  ent_t q_a[$];
  ent_t q_b[$];

  // Expected bus state after rising edge c (c=1 is the first edge with rst low)
  function automatic ent_t exp_bus(int n, int c);
    ent_t e;
    int k, per, p, r;
    e = '{en: 1'b0, we: 1'b0, add: 32'd0, data: 32'd0, done: 1'b0};
    k = c - 1;
    per = 2 * n + 1;
    p = k / per;
    r = k % per;
    if (p >= 2) e.done = 1'b1;
    else if (r < n) begin
      e.en = 1'b1; e.we = 1'b1; e.add = r;
      e.data = (p == 1) ? ((~r) & 255) : (r & 255);
    end else if (r < 2 * n) begin
      e.en = 1'b1; e.add = r - n;
    end
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_done(output int cyc);
    cyc = 0;
    while (!done_a && cyc < 5000) begin
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    total++;
    if (done_a !== 1'b1) begin
      $display("FAIL run_to_done: done=%0b after %0d cycles, expected 1", done_a, cyc);
      bad++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus_a.add !== 10'd0) begin $display("FAIL reset_add: got %0h exp 0", bus_a.add); bad++; end
    total++; if (bus_a.dataW !== 8'd0) begin $display("FAIL reset_dataW: got %0h exp 0", bus_a.dataW); bad++; end
    total++; if (bus_a.en !== 1'b0) begin $display("FAIL reset_en: got %0b exp 0", bus_a.en); bad++; end
    total++; if (bus_a.we !== 1'b0) begin $display("FAIL reset_we: got %0b exp 0", bus_a.we); bad++; end
    total++; if (done_a !== 1'b0) begin $display("FAIL reset_done: got %0b exp 0", done_a); bad++; end
    total++; if (error_a !== 1'b0) begin $display("FAIL reset_error: got %0b exp 0", error_a); bad++; end
    total++; if (err_count_a !== 12'd0) begin $display("FAIL reset_err_count: got %0d exp 0", err_count_a); bad++; end
    total++; if (err_add_a !== 10'd0) begin $display("FAIL reset_err_add: got %0h exp 0", err_add_a); bad++; end
    total++;
    if ({bus_b.add, bus_b.dataW, bus_b.en, bus_b.we, done_b, error_b, err_count_b, err_add_b} !== 29'd0) begin
      $display("FAIL reset_small: outputs not all zero");
      bad++;
    end
  endtask

  task automatic test_ideal_sequence();
    ent_t e;
    logic [7:0] w1ff [2];
    int  done_at_a, done_at_b;
    bit  ok_a, ok_b;
    fault_mode = 0;
    w1ff[0] = 8'h5A; w1ff[1] = 8'h5A;
    done_at_a = -1; done_at_b = -1;
    ok_a = 1'b1; ok_b = 1'b1;
    for (int c = 1; c <= 4099; c++) q_a.push_back(exp_bus(1024, c));
    for (int c = 1; c <= 67; c++) q_b.push_back(exp_bus(16, c));
    do_reset();
    for (int c = 1; c <= 4099; c++) begin
      @(posedge clk); @(negedge clk);
      if (done_a && done_at_a < 0) done_at_a = c;
      if (done_b && done_at_b < 0) done_at_b = c;
      if (bus_a.en && bus_a.we && bus_a.add == 10'h1FF) w1ff[(c < 2050) ? 0 : 1] = bus_a.dataW;
      e = q_a.pop_front();
      if (ok_a) begin
        total++;
        if ({bus_a.en, bus_a.we, 22'd0, bus_a.add, 24'd0, bus_a.dataW, done_a} !== {e.en, e.we, e.add, e.data, e.done}) begin
          $display("FAIL bus_a cycle %0d: got en=%0b we=%0b add=%0h dataW=%0h done=%0b exp en=%0b we=%0b add=%0h dataW=%0h done=%0b",
                   c, bus_a.en, bus_a.we, bus_a.add, bus_a.dataW, done_a, e.en, e.we, e.add, e.data, e.done);
          bad++; ok_a = 1'b0;
        end
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        if (ok_b) begin
          total++;
          if ({bus_b.en, bus_b.we, 28'd0, bus_b.add, 24'd0, bus_b.dataW, done_b} !== {e.en, e.we, e.add, e.data, e.done}) begin
            $display("FAIL bus_b cycle %0d: got en=%0b we=%0b add=%0h dataW=%0h done=%0b exp en=%0b we=%0b add=%0h dataW=%0h done=%0b",
                     c, bus_b.en, bus_b.we, bus_b.add, bus_b.dataW, done_b, e.en, e.we, e.add, e.data, e.done);
            bad++; ok_b = 1'b0;
          end
        end
      end
    end
    total++; if (done_at_a - 1 != 4098) begin $display("FAIL done_latency: got %0d exp 4098", done_at_a - 1); bad++; end
    total++; if (error_a !== 1'b0) begin $display("FAIL ideal_error: got %0b exp 0", error_a); bad++; end
    total++; if (err_count_a !== 12'd0) begin $display("FAIL ideal_err_count: got %0d exp 0", err_count_a); bad++; end
    total++; if (err_add_a !== 10'd0) begin $display("FAIL ideal_err_add: got %0h exp 0", err_add_a); bad++; end
    total++; if (w1ff[0] !== 8'hFF) begin $display("FAIL write_1ff_pass0: got %0h exp ff", w1ff[0]); bad++; end
    total++; if (w1ff[1] !== 8'h00) begin $display("FAIL write_1ff_pass1: got %0h exp 00", w1ff[1]); bad++; end
    total++; if (done_at_b - 1 != 66) begin $display("FAIL small_done_latency: got %0d exp 66", done_at_b - 1); bad++; end
    total++; if (error_b !== 1'b0) begin $display("FAIL small_error: got %0b exp 0", error_b); bad++; end
  endtask

  task automatic test_stuck_bit3();
    int cyc;
    fault_mode = 1;
    do_reset();
    run_to_done(cyc);
    total++; if (err_count_a !== 12'd1024) begin $display("FAIL stuck_err_count: got %0d exp 1024", err_count_a); bad++; end
    total++; if (err_add_a !== 10'h008) begin $display("FAIL stuck_err_add: got %0h exp 008", err_add_a); bad++; end
    total++; if (error_a !== 1'b1) begin $display("FAIL stuck_error: got %0b exp 1", error_a); bad++; end
  endtask

  task automatic test_single_corrupt();
    int cyc;
    fault_mode = 2;
    do_reset();
    run_to_done(cyc);
    total++; if (err_count_a !== 12'd1) begin $display("FAIL corrupt_err_count: got %0d exp 1", err_count_a); bad++; end
    total++; if (err_add_a !== 10'h155) begin $display("FAIL corrupt_err_add: got %0h exp 155", err_add_a); bad++; end
    total++; if (error_a !== 1'b1) begin $display("FAIL corrupt_error: got %0b exp 1", error_a); bad++; end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    ent_t e;
    fault_mode = 2;
    do_reset();
    // cycle 3500 lies in pass-1 READ, after the corrupted read of 0x155
    repeat (3500) begin @(posedge clk); @(negedge clk); end
    total++; if (error_a !== 1'b1) begin $display("FAIL mid_pre_error: got %0b exp 1", error_a); bad++; end
    fault_mode = 0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    total++;
    if ({bus_a.add, bus_a.dataW, bus_a.en, bus_a.we, done_a, error_a, err_count_a, err_add_a} !== 42'd0) begin
      $display("FAIL mid_reset_outputs: add=%0h dataW=%0h en=%0b we=%0b done=%0b error=%0b err_count=%0d err_add=%0h exp all 0",
               bus_a.add, bus_a.dataW, bus_a.en, bus_a.we, done_a, error_a, err_count_a, err_add_a);
      bad++;
    end
    for (int c = 1; c <= 3; c++) q_a.push_back(exp_bus(1024, c));
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); @(negedge clk);
      e = q_a.pop_front();
      total++;
      if ({bus_a.en, bus_a.we, 22'd0, bus_a.add, 24'd0, bus_a.dataW} !== {e.en, e.we, e.add, e.data}) begin
        $display("FAIL mid_restart cycle %0d: got en=%0b we=%0b add=%0h dataW=%0h exp en=%0b we=%0b add=%0h dataW=%0h",
                 c, bus_a.en, bus_a.we, bus_a.add, bus_a.dataW, e.en, e.we, e.add, e.data);
        bad++;
      end
    end
    run_to_done(cyc);
    total++; if (cyc + 3 - 1 != 4098) begin $display("FAIL mid_done_latency: got %0d exp 4098", cyc + 2); bad++; end
    total++; if (err_count_a !== 12'd0) begin $display("FAIL mid_err_count: got %0d exp 0", err_count_a); bad++; end
  endtask

  initial begin
    test_reset();
    test_ideal_sequence();
    test_stuck_bit3();
    test_single_corrupt();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_tester.md
# memory_tester

Self-checking stimulus engine for a single-port synchronous RAM (`memory`, ports clk/add/din/dout/en/we). After reset it runs a write-all/read-all/compare sequence over the full address space in two passes, first with a true pattern and then with an inverted pattern. It then reports completion and error status. It sits in the simulation and bring-up harness; a higher level stops the run when `done` rises.

## Interface
Parameters:
- `ADD_WIDTH`, default 10: RAM address width; the tester covers 2^ADD_WIDTH words.
- `DAT_WIDTH`, default 8: RAM data width.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: reset. Synchronous and active-high.
- `add`  out  ADD_WIDTH: RAM address.
- `dataW`  out  DAT_WIDTH: RAM write data. Connects to RAM `din`.
- `dataR`  in  DAT_WIDTH: RAM read data. Connects to RAM `dout`; valid one cycle after a read.
- `en`  out  1: RAM enable.
- `we`  out  1: RAM write enable. Meaningful only while `en`=1.
- `done`  out  1: sequence finished. Sticky until reset.
- `error`  out  1: at least one read-back compare failed. Sticky.
- `err_count`  out  ADD_WIDTH+2: number of failed compares. Saturates at all-ones.
- `err_add`  out  ADD_WIDTH: address of the first failing compare. Holds 0 if no failure.

## Operation
- Pattern: `pat(p,i)` = `i` zero-extended or truncated to DAT_WIDTH, XOR `{DAT_WIDTH{p}}`. Pass p=0 uses the plain pattern; p=1 uses the inverted pattern.
- FSM states and transitions:
  - `IDLE`: entered during reset. Exits on the first cycle with `rst`=0.
  - `WRITE`: `en`=1, `we`=1, `add`=i, `dataW`=pat(p,i). Runs i = 0 … 2^ADD_WIDTH−1.
  - `READ`: `en`=1, `we`=0, `add`=i. Runs i = 0 … 2^ADD_WIDTH−1.
  - `DRAIN`: one cycle with `en`=0, used to compare the last read.
  - After DRAIN: if p=0, set p=1 and go to `WRITE`; otherwise go to `DONE`.
  - `DONE`: `en`=0, `we`=0, `done`=1. Stays here until reset.
- Compare pipeline: a read issued in cycle t is checked against `dataR` in cycle t+1. The expected value and address are registered alongside the read.
- On a mismatch:
  - `err_count` increments, saturating.
  - `error` is set.
  - `err_add` is captured only on the first mismatch.
- Address counter: wraps from all-ones to 0 at each phase boundary. The wrap terminates the phase; no extra cycle is inserted.
- Outside WRITE: `we`=0. Outside WRITE/READ: `en`=0. `dataW` is don't-care outside WRITE; drive 0.

## Timing
- Reset values: `add`=0, `dataW`=0, `en`=0, `we`=0, `done`=0, `error`=0, `err_count`=0, `err_add`=0. FSM is in `IDLE` with p=0.
- All outputs are registered.
- Call cycle 1 the first rising edge at which `rst`=0 is sampled. The first write (add 0) is presented after edge 1.
- Each pass takes 2·2^ADD_WIDTH + 1 cycles.
- `done` rises 2·(2·2^ADD_WIDTH+1) cycles after the first write is presented. With the defaults this is 4098 cycles.
- `error` and `err_count` are final in the same cycle `done` rises.
- Asserting `rst` mid-sequence on edge k: every output returns to its reset value after edge k, and the sequence restarts from pass 0, address 0.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, WRITE, READ, DRAIN, DONE);
  - the pattern function `pat(p,i)`.
- One natural sub-module: `rd_checker`. It contains the registered expected data/address, the comparator, the saturating error counter and the first-error capture. The FSM and address/pass counters stay in the top.

## Test plan
- Ideal RAM model (1-cycle read latency), ADD_WIDTH=10, DAT_WIDTH=8:
  - `done` rises exactly 4098 cycles after the first write.
  - `error`=0, `err_count`=0.
  - Write at add 0x1FF carries 0xFF in pass 0 and 0x00 in pass 1.
- Bus check: the first 1024 active cycles have `en`=1, `we`=1, `add`=0…1023; the next 1024 have `en`=1, `we`=0; then one cycle with `en`=0.
- Fault injection, stuck-at-0 on `dout` bit 3:
  - Every word with bit 3 =1 fails in pass 0, and every word with bit 3 =0 fails in pass 1.
  - Result: `err_count`=1024, `err_add`=0x008, `error`=1.
- Single-address corruption: the model flips the data read at add 0x155 in pass 1 only. Result: `err_count`=1, `err_add`=0x155.
- Reset mid-run: assert `rst` for 1 cycle during pass 1 READ.
  - Outputs return to reset values.
  - Sequence restarts at pass 0, add 0.
  - `done` again arrives 4098 cycles later.
- Small config, ADD_WIDTH=4, DAT_WIDTH=8: `done` rises 66 cycles after the first write; pass-1 data equals ~i.
